// File: rtl/oam_dma_master.sv
// Sprite (OAM) DMA bus initiator: copies CPU page {PAGE,00..FF} to DEST_ADDR.
// Optional feature: define OAM_DMA_ABORT_EN to add the ABORT input.
module oam_dma_master #(
  parameter logic [15:0] DEST_ADDR = 16'h2004,
  parameter int          XFER_LEN  = 256
) (
  input  logic        PHI0,
  input  logic        n_RES,
  input  logic        W4014,
  input  logic [7:0]  DB_in,
  input  logic        CPU_RD,
`ifdef OAM_DMA_ABORT_EN
  input  logic        ABORT,
`endif
  output logic        RDY,
  output logic        BUS_EN,
  output logic [15:0] ADDR,
  output logic        RnW,
  output logic [7:0]  DB_out,
  output logic        BUSY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  // The byte counter is 8 bits wide, so XFER_LEN of 256 is the only meaningful value.
  localparam logic [7:0] LAST_CNT = 8'(XFER_LEN - 1);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       put_q;
  logic [7:0] page_q;
  logic [7:0] cnt_q;
  logic [7:0] data_q;
  logic       abort_req;

`ifdef OAM_DMA_ABORT_EN
  assign abort_req = ABORT && (state_q != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (W4014) state_d = S_HALT;
      // put_q=1 now means the next cycle is a get cycle, where READ must land.
      S_HALT:  if (CPU_RD) state_d = put_q ? S_READ : S_ALIGN;
      S_ALIGN: state_d = S_READ;
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = (cnt_q == LAST_CNT) ? S_IDLE : S_READ;
      default: state_d = S_IDLE;
    endcase
    if (abort_req) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      state_q <= S_IDLE;
      put_q   <= 1'b0;
      page_q  <= 8'h00;
      cnt_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      put_q   <= ~put_q;
      case (state_q)
        S_IDLE: begin
          if (W4014) begin
            page_q <= DB_in;
            cnt_q  <= 8'h00;
          end
        end
        S_READ:  data_q <= DB_in;
        S_WRITE: cnt_q  <= cnt_q + 8'd1;
        default: ;
      endcase
      if (abort_req) cnt_q <= 8'h00;
    end
  end

  assign BUSY   = (state_q != S_IDLE);
  assign RDY    = ~BUSY;
  assign BUS_EN = (state_q == S_READ) || (state_q == S_WRITE);
  assign RnW    = (state_q != S_WRITE);
  assign DB_out = data_q;

  always_comb begin
    ADDR = 16'h0000;
    if (state_q == S_READ)       ADDR = {page_q, cnt_q};
    else if (state_q == S_WRITE) ADDR = DEST_ADDR;
  end

endmodule

// File: doc/oam_dma_master.md
# oam_dma_master

Sprite (OAM) DMA bus initiator on the CPU side of the PPU register interface. A write to $4014 starts the transfer. The block halts the CPU through RDY, then runs 256 read/write pairs: each byte is read from CPU page `{PAGE, 00..FF}` and written to PPU register $2004. It drives the same RS/RnW/data bus that the PPU register decoder responds to, so it is the writer for the OAMDATA port.

## Interface
Parameters:
- `DEST_ADDR`, default 16'h2004: destination address for every write cycle.
- `XFER_LEN`, default 256: bytes per transfer. The counter is 8 bits wide, so only 256 is legal.

Ports:
- `PHI0` in 1: the single block clock. All state updates on the rising edge.
- `n_RES` in 1: reset, asynchronous and active-low. Asserting it clears all state immediately.
- `W4014` in 1: one-cycle strobe indicating a CPU write to $4014.
- `DB_in` in 8: data bus. Sampled as `PAGE` when `W4014` is high; sampled as read data in READ.
- `CPU_RD` in 1: the CPU's current cycle is a read. RDY only halts the CPU on reads.
- `RDY` out 1: CPU ready. 0 while DMA owns the bus.
- `BUS_EN` out 1: DMA drives `ADDR`, `RnW` and `DB_out`.
- `ADDR` out 16: bus address.
- `RnW` out 1: 1 = read, 0 = write.
- `DB_out` out 8: write data, valid in WRITE.
- `BUSY` out 1: a transfer is in progress.
- `ABORT` in 1: present only with `OAM_DMA_ABORT_EN`.

## Operation
- **Parity flop `PUT`**
  - Reset value 0; toggles every PHI0.
  - `PUT`=0 is a get (read) cycle; `PUT`=1 is a put (write) cycle.
- **States:** IDLE, HALT, ALIGN, READ, WRITE.
- **IDLE**
  - If `W4014`=1: latch `PAGE`=`DB_in`, clear `CNT` to 0, go to HALT.
- **HALT**
  - `RDY`=0, `BUS_EN`=0.
  - Stay here while `CPU_RD`=0.
  - Once `CPU_RD`=1: next state is READ if the next cycle is a get cycle, otherwise ALIGN.
- **ALIGN**
  - One dummy cycle with `RDY`=0 and `BUS_EN`=0.
  - Next state READ.
- **READ**
  - `BUS_EN`=1, `RnW`=1, `ADDR`={`PAGE`,`CNT`}.
  - `DB_in` is latched into the data register at the end of the cycle.
  - Next state WRITE.
- **WRITE**
  - `BUS_EN`=1, `RnW`=0, `ADDR`=`DEST_ADDR`, `DB_out`=latched byte.
  - `CNT` increments modulo 256.
  - If `CNT` was 255: go to IDLE, restoring `RDY`=1. Otherwise go to READ.
- **Outside READ/WRITE:** `ADDR`=0, `RnW`=1, `DB_out` holds its last value.
- **`BUSY`:** 1 in every state except IDLE.
- **`W4014` while `BUSY`=1:** ignored. `PAGE` is unchanged and the running transfer completes.

## Timing
- Reset values: `RDY`=1, `BUS_EN`=0, `RnW`=1, `ADDR`=0, `DB_out`=0, `BUSY`=0; internally `PUT`=0, `CNT`=0, state IDLE.
- `RDY` falls in the cycle after the `W4014` cycle.
- With `CPU_RD`=1 already in HALT, the transfer takes 1 + {0|1} + 512 cycles, i.e. 513 or 514, from `RDY` falling to `RDY` rising.
- Each extra HALT cycle with `CPU_RD`=0 adds 1.
- READ always falls on a get cycle and WRITE always on a put cycle; no other interleaving is legal.
- Page wrap: the address low byte runs 00..FF and never carries into `PAGE`.
- `n_RES` asserted mid-transfer:
  - all outputs take their reset values asynchronously;
  - no partial write completes after release;
  - `RDY` returns to 1.

## Configuration
- `OAM_DMA_ABORT_EN` defined:
  - `ABORT` input exists.
  - `ABORT`=1 sampled in any non-IDLE state forces IDLE on the next edge, with `RDY`=1 and `BUS_EN`=0.
  - A WRITE in progress still completes in that cycle.
  - `CNT` is cleared.
- Undefined: no `ABORT` port; transfers always run to completion or reset.

## Test plan
- **Even-aligned transfer.** Reset, then `W4014` with `DB_in`=8'h02 and `CPU_RD`=1.
  - First READ `ADDR`=16'h0200, followed by a write to 16'h2004.
  - Last READ `ADDR`=16'h02FF.
  - `RDY` low for exactly 513 cycles.
- **Odd alignment.** Same stimulus, with the strobe one cycle later so HALT exits onto a put cycle.
  - One ALIGN cycle occurs.
  - `RDY` low for 514 cycles.
  - Every READ has `PUT`=0.
- **Data integrity.** Memory model returns `~ADDR[7:0]`.
  - Write N carries `DB_out`=~N for N=0..255.
  - 256 writes total, none extra.
- **CPU on write cycles.** Hold `CPU_RD`=0 for 3 cycles after the strobe.
  - HALT lasts 4 cycles.
  - `BUS_EN` stays 0 until `CPU_RD`=1.
- **Restart while busy, then reset.** Issue a second `W4014`=8'h07 mid-transfer.
  - It is ignored and `PAGE` stays 02.
  - Pulse `n_RES` low at write 100: outputs immediately take reset values, and no further bus cycles occur.
- **Abort (`OAM_DMA_ABORT_EN` defined).** Pulse `ABORT` at READ 10.
  - IDLE next edge, `RDY`=1.
  - A fresh `W4014` restarts from offset 00.
